// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel and the
// IF/ID instruction hand-off channel.
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_id_valid_inst;
    logic [31:0] if_id_PC;
    logic [31:0] if_id_IR;
    logic        id_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_id_valid_inst, if_id_PC, if_id_IR,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_id_valid_inst, if_id_PC, if_id_IR,
        output id_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: keeps the fetch PC, issues in-order memory
// requests under a credit limit, buffers responses and handles branch redirects.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_take_branch,
    input  logic [31:0]       ex_target_PC,
    if_fetch_unit_if.master   fetch
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = QUEUE_DEPTH[CW:0];

    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [31:0]         pc_q [QUEUE_DEPTH];
    logic [31:0]         ir_q [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0] filled_q;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       pend_q, pend_d;
    logic [CW-1:0]       drop_q, drop_d;

    logic [CW:0]         occ_s;
    logic                req_valid_s, alloc_s, fill_s, drop_resp_s;
    logic                valid_s, pop_s;
    logic [CW-1:0]       nfilled_s;
    logic [PW-1:0]       fill_idx_s;
    logic [31:0]         target_s;

    // Credit, handshake and queue-index decode
    always_comb begin
        occ_s       = {1'b0, count_q} + {1'b0, drop_q};
        req_valid_s = rst && (occ_s < DEPTH_C) && !ex_take_branch;
        alloc_s     = req_valid_s && fetch.imem_req_ready;
        drop_resp_s = fetch.imem_resp_valid && (drop_q != {CW{1'b0}});
        fill_s      = fetch.imem_resp_valid && (drop_q == {CW{1'b0}});
        // Filled entries are contiguous from head, so the oldest unfilled one
        // sits right after them.
        nfilled_s   = count_q - pend_q;
        fill_idx_s  = head_q + nfilled_s[PW-1:0];
        valid_s     = filled_q[head_q] && (count_q != {CW{1'b0}});
        pop_s       = valid_s && fetch.id_ready;
        target_s    = ex_target_PC & 32'hFFFF_FFFC;
    end

    // Next-state for PC, pointers and occupancy counters; redirect wins
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        if (ex_take_branch) begin
            fetch_pc_d = target_s;
            head_d     = {PW{1'b0}};
            tail_d     = {PW{1'b0}};
            count_d    = {CW{1'b0}};
            pend_d     = {CW{1'b0}};
            // Every outstanding response is stale; one may be consumed right now.
            drop_d     = drop_q + pend_q - CW'(fetch.imem_resp_valid);
        end else begin
            if (alloc_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tail_d     = tail_q + PW'(1);
            end else begin
                tail_d     = tail_q;
            end
            head_d  = head_q + PW'(pop_s);
            count_d = count_q + CW'(alloc_s) - CW'(pop_s);
            pend_d  = pend_q + CW'(alloc_s) - CW'(fill_s);
            drop_d  = drop_q - CW'(drop_resp_s);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            pend_q     <= {CW{1'b0}};
            drop_q     <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
        end
    end

    // Queue entry storage: allocate at tail, fill oldest unfilled entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                pc_q[i] <= 32'h0000_0000;
                ir_q[i] <= 32'h0000_0000;
            end
            filled_q <= {QUEUE_DEPTH{1'b0}};
        end else if (!ex_take_branch) begin
            if (alloc_s) begin
                pc_q[tail_q]     <= fetch_pc_q;
                filled_q[tail_q] <= 1'b0;
            end
            if (fill_s) begin
                ir_q[fill_idx_s]     <= fetch.imem_resp_data;
                filled_q[fill_idx_s] <= 1'b1;
            end
        end else begin
            filled_q <= filled_q;
        end
    end

    assign fetch.imem_req_valid   = req_valid_s;
    assign fetch.imem_req_addr    = fetch_pc_q;
    assign fetch.if_id_valid_inst = valid_s;
    assign fetch.if_id_PC         = pc_q[head_q];
    assign fetch.if_id_IR         = ir_q[head_q];
endmodule
